uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, configurable frame format (data width, parity, stop bits) and oversampling ratio. It sits between the RSA datapath (or any byte producer) and the serial TX pin. It accepts words through a valid/ready handshake and emits back-to-back frames with no idle gap while data is queued. A shared baud-tick generator provides the timing strobe.

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- PARITY, 0: parity mode; 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- OVERSAMPLE, 16: baud_tick pulses per bit period; legal values ≥2.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥2.
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clk strobe at OVERSAMPLE × baud rate.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  DATA_BITS  word to transmit.
- in_ready  output  1  FIFO can accept a word this cycle.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  a frame is in progress (state ≠ IDLE).
- fifo_level  output  $clog2(FIFO_DEPTH+1)  words currently queued.

## Operation
- Push: a word is written to the FIFO on any clk edge where in_valid && in_ready. in_ready = !full, with no same-cycle pop credit. in_ready is 0 while rst is high.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on the edge where the FIFO is non-empty. That edge pops the head word into the shift register, sets tx<=0, and clears the tick counter and bit counter.
- Bit period: a 0..OVERSAMPLE-1 counter advances only on baud_tick. A bit ends on the edge where baud_tick=1 and the count is OVERSAMPLE-1. On that edge the counter wraps to 0 and the next bit's tx value is registered.
- START -> DATA: tx <= shift[0] (LSB first).
- DATA: shift right each bit end. After DATA_BITS bits, go to PARITY if PARITY≠0, else go to STOP.
- PARITY: tx = ^word for even, ~^word for odd. The parity is computed on the popped word, not on the shifted value.
- STOP: tx=1 for STOP_BITS bit periods.
- At the end of the final stop bit:
  - If the FIFO is non-empty: pop the next word and go to START on the same edge (tx<=0), leaving no idle gap.
  - Otherwise: go to IDLE.
- Simultaneous push and pop: both occur. fifo_level is unchanged, and the pointers advance independently.
- Push into an empty FIFO while IDLE: the word is popped on the next edge at the earliest (no bypass).
- fifo_level counts FIFO contents only. The word being transmitted is not counted.

## Timing
- Reset values: tx=1, busy=0, fifo_level=0, in_ready=0 during rst and 1 on the first cycle after rst deasserts, state=IDLE, FIFO pointers 0.
- Reset mid-frame: the frame is aborted and the FIFO flushed. tx=1 on the edge after rst is sampled high.
- Latency: tx falls on the first clk edge after the push edge, when the FIFO was empty and the FSM was IDLE.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × OVERSAMPLE baud_ticks. The first bit period can be up to one baud_tick interval longer, because the counter starts from the pop edge rather than from a tick.
- baud_tick high on every clk is legal: each bit then lasts exactly OVERSAMPLE clks.
- busy rises on the pop edge. It falls on the edge that ends the last stop bit, and only when the FIFO is empty.
- tx and busy are glitch-free registered outputs. in_ready and fifo_level are registered-state derived.

## Test plan
- 8N1, OVERSAMPLE=16, baud_tick every clk, push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1. Each value holds 16 clks. busy falls after 160 clks; tx stays 1 after that.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, push 0x35 -> frame 0,1,0,1,0,1,1,0,0,1,1 (parity = 0, four ones). Frame length 11×OVERSAMPLE.
- PARITY=2, push 0x00 -> parity bit = 1. Push 0xFF -> parity bit = 1 (eight ones, odd parity adds one).
- FIFO_DEPTH=4, hold in_valid for 6 consecutive cycles with distinct data:
  - 1st word popped; fifo_level reaches 4; in_ready=0; 6th word held until a pop frees space.
  - All accepted words are emitted in order with no gap between stop bit and next start bit.
- Sparse baud_tick (1 in 5 clks), single 0x5A -> each bit spans 16 ticks (80 clks ±one tick interval on the first bit). LSB first.
- Assert rst for 1 cycle mid-DATA with 2 words queued -> tx=1, busy=0, fifo_level=0 next cycle. No further frames are emitted.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Producer-to-transmitter word handshake: a word moves on a clk edge with in_valid && in_ready.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small input FIFO; configurable frame format and oversampling,
// frames leave back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               baud_tick,
  uart_tx_fifo_if.slave                      in_if,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     count;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n, word, word_n;
  logic [CNT_W-1:0]     tick_cnt, tick_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic                 tx_n, busy_n, bit_end;

  assign full            = (count == LVL_W'(FIFO_DEPTH));
  assign empty           = (count == '0);
  assign in_if.in_ready  = !rst && !full;
  assign push            = in_if.in_valid && in_if.in_ready;
  assign head            = mem[rd_ptr];
  assign fifo_level      = count;
  assign bit_end         = baud_tick && (tick_cnt == CNT_W'(OVERSAMPLE - 1));

  // FIFO storage; not reset, occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_if.in_data;
  end

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State and frame datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shift    <= '0;
      word     <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      word     <= word_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      tx       <= tx_n;
      busy     <= busy_n;
    end
  end

  // Next state, next tx level and FIFO pop
  always_comb begin
    state_n = state;
    shift_n = shift;
    word_n  = word;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    tx_n    = tx;
    busy_n  = busy;
    pop     = 1'b0;

    if (state != S_IDLE && baud_tick) tick_n = bit_end ? '0 : tick_cnt + CNT_W'(1);

    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          word_n  = head;
          tick_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_n    = shift[0];
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_n = '0;
            if (PARITY != 0) begin
              // parity comes from the popped word, the shift register is already consumed
              tx_n    = (PARITY == 1) ? ^word : ~^word;
              state_n = S_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
            tx_n  = shift[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_n    = 1'b1;
          bit_n   = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            if (!empty) begin
              pop     = 1'b1;
              shift_n = head;
              word_n  = head;
              tick_n  = '0;
              bit_n   = '0;
              tx_n    = 1'b0;
              state_n = S_START;
            end else begin
              busy_n  = 1'b0;
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule
